// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } alu_state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative radix-2 Booth multiplier and non-restoring magnitude divider,
// one iteration per cycle, with sign fix-up presented on the result outputs.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] res_lo_c,
  output logic [WIDTH-1:0] res_hi_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned RW    = WIDTH + 2;

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic             div_mode;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qr;
  logic             q_m1;
  logic [WIDTH-1:0] m;
  logic [RW-1:0]    rem;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [RW-1:0]    d_ext;
  logic [WIDTH:0]   booth_sum;
  logic [RW-1:0]    div_sh;
  logic [RW-1:0]    div_nx;
  logic [WIDTH-1:0] rem_mag;

  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;
  assign d_ext = RW'(m);

  // One Booth step (accumulator is one bit wider so m = most-negative cannot overflow)
  // and one non-restoring divide step.
  always_comb begin
    booth_sum = acc;
    case ({qr[0], q_m1})
      2'b01:   booth_sum = acc + {m[WIDTH-1], m};
      2'b10:   booth_sum = acc - {m[WIDTH-1], m};
      default: booth_sum = acc;
    endcase
    div_sh = {rem[RW-2:0], qr[WIDTH-1]};
    div_nx = rem[RW-1] ? (div_sh + d_ext) : (div_sh - d_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      cnt      <= '0;
      fin      <= 1'b0;
      div_mode <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      acc      <= '0;
      qr       <= '0;
      q_m1     <= 1'b0;
      m        <= '0;
      rem      <= '0;
    end else if (go) begin
      run      <= 1'b1;
      cnt      <= '0;
      fin      <= 1'b0;
      div_mode <= is_div;
      q_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg    <= a[WIDTH-1];
      acc      <= '0;
      q_m1     <= 1'b0;
      rem      <= '0;
      m        <= is_div ? mag_b : a;
      qr       <= is_div ? mag_a : b;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
      // fin marks the cycle in which the final iteration is performed
      fin <= (cnt == CNT_W'(WIDTH - 2));
      if (cnt == CNT_W'(WIDTH - 1)) begin
        run <= 1'b0;
      end
      if (div_mode) begin
        rem <= div_nx;
        qr  <= {qr[WIDTH-2:0], ~div_nx[RW-1]};
      end else begin
        acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        qr   <= {booth_sum[0], qr[WIDTH-1:1]};
        q_m1 <= qr[0];
      end
    end else begin
      fin <= 1'b0;
    end
  end

  // Final remainder restore, then quotient truncates toward zero and remainder follows the dividend.
  always_comb begin
    rem_mag  = WIDTH'(rem[RW-1] ? (rem + d_ext) : rem);
    res_lo_c = qr;
    res_hi_c = acc[WIDTH-1:0];
    if (div_mode) begin
      res_lo_c = q_neg ? -qr : qr;
      res_hi_c = r_neg ? -rem_mag : rem_mag;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed MUL/DIV
// behind a start/done handshake, with registered LO/HI results and dbz/err flags.
module seq_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zlowout,
  output logic [WIDTH-1:0] Zhighout,
  output logic             dbz,
  output logic             err
);

  import alu_pkg::*;

  alu_state_t       state;
  logic [SHAMT_W-1:0] sh_c;
  logic [SHAMT_W-1:0] rol_amt_c;
  logic [WIDTH-1:0] alu_c;
  logic             unk_c;
  logic             is_div_c;
  logic             div_zero_c;
  logic             go_c;
  logic             fin;
  logic [WIDTH-1:0] md_lo_c;
  logic [WIDTH-1:0] md_hi_c;

  assign sh_c       = B[SHAMT_W-1:0];
  assign rol_amt_c  = SHAMT_W'(0) - sh_c;
  assign is_div_c   = (opcode == OP_DIV);
  assign div_zero_c = (B == '0);
  assign go_c       = (state == ST_IDLE) && start &&
                      ((opcode == OP_MUL) || (is_div_c && !div_zero_c));

  // Single-cycle operation results
  always_comb begin
    alu_c = '0;
    unk_c = 1'b0;
    case (opcode)
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_ADD:  alu_c = A + B;
      OP_SUB:  alu_c = A - B;
      OP_SHR:  alu_c = A >> sh_c;
      OP_SHRA: alu_c = $signed(A) >>> sh_c;
      OP_SHL:  alu_c = A << sh_c;
      OP_ROR:  alu_c = WIDTH'({A, A} >> sh_c);
      OP_ROL:  alu_c = WIDTH'({A, A} >> rol_amt_c);
      OP_NEG:  alu_c = -A;
      OP_NOT:  alu_c = ~A;
      OP_MUL, OP_DIV: alu_c = '0;
      default: begin
        alu_c = '0;
        unk_c = 1'b1;
      end
    endcase
  end

  seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clock),
    .rst_n   (clear),
    .go      (go_c),
    .is_div  (is_div_c),
    .a       (A),
    .b       (B),
    .fin     (fin),
    .res_lo_c(md_lo_c),
    .res_hi_c(md_hi_c)
  );

  // Sequencer and output registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Zlowout  <= '0;
      Zhighout <= '0;
      dbz      <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (opcode == OP_MUL) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else if (is_div_c && !div_zero_c) begin
              state <= ST_DIV;
              busy  <= 1'b1;
            end else if (is_div_c) begin
              Zlowout  <= '1;
              Zhighout <= A;
              dbz      <= 1'b1;
              err      <= 1'b0;
              done     <= 1'b1;
            end else begin
              Zlowout  <= alu_c;
              Zhighout <= '0;
              dbz      <= 1'b0;
              err      <= unk_c;
              done     <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (fin) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          Zlowout  <= md_lo_c;
          Zhighout <= md_hi_c;
          dbz      <= 1'b0;
          err      <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver queues model results, negedge monitor checks each done.
module tb_seq_alu;

  localparam int unsigned W = 32;

  localparam logic [4:0] C_AND  = 5'b00101;
  localparam logic [4:0] C_OR   = 5'b00110;
  localparam logic [4:0] C_ADD  = 5'b00011;
  localparam logic [4:0] C_SUB  = 5'b00100;
  localparam logic [4:0] C_MUL  = 5'b10000;
  localparam logic [4:0] C_DIV  = 5'b01111;
  localparam logic [4:0] C_SHR  = 5'b01001;
  localparam logic [4:0] C_SHRA = 5'b01010;
  localparam logic [4:0] C_SHL  = 5'b01011;
  localparam logic [4:0] C_ROR  = 5'b00111;
  localparam logic [4:0] C_ROL  = 5'b01000;
  localparam logic [4:0] C_NEG  = 5'b10001;
  localparam logic [4:0] C_NOT  = 5'b10010;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   opcode = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Zlowout;
  logic [W-1:0] Zhighout;
  logic         dbz;
  logic         err;

  seq_alu #(.WIDTH(W)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .opcode  (opcode),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .Zlowout (Zlowout),
    .Zhighout(Zhighout),
    .dbz     (dbz),
    .err     (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic [4:0] ops[13] = '{C_AND, C_OR, C_ADD, C_SUB, C_MUL, C_DIV, C_SHR,
                          C_SHRA, C_SHL, C_ROR, C_ROL, C_NEG, C_NOT};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_multi(input logic [4:0] op, input logic [31:0] b);
    return (op == C_MUL) || (op == C_DIV && b != 0);
  endfunction

  // Behavioural reference: plain wide arithmetic on signed/unsigned values
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sbv, p, q, r;
    int     s;
    logic [31:0] x;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    s   = int'(b % 32);
    e.lo = 0; e.hi = 0; e.dbz = 0; e.err = 0; e.due = 0;
    case (op)
      C_AND:  e.lo = a & b;
      C_OR:   e.lo = a | b;
      C_ADD:  e.lo = a + b;
      C_SUB:  e.lo = a - b;
      C_SHR:  e.lo = a >> s;
      C_SHRA: e.lo = $signed(a) >>> s;
      C_SHL:  e.lo = a << s;
      C_ROR: begin
        x = a;
        for (int i = 0; i < s; i++) x = {x[0], x[31:1]};
        e.lo = x;
      end
      C_ROL: begin
        x = a;
        for (int i = 0; i < s; i++) x = {x[30:0], x[31]};
        e.lo = x;
      end
      C_NEG:  e.lo = 32'd0 - a;
      C_NOT:  e.lo = ~a;
      C_MUL: begin
        p = sa * sbv;
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      C_DIV: begin
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.dbz = 1'b1;
        end else begin
          q = sa / sbv;
          r = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one operation at a negedge; returns at a negedge
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    exp_t e;
    int   guard;
    bit   mc;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: busy still %b after %0d cycles", busy, guard);
    end
    mc    = is_multi(op, b);
    e     = model(op, a, b);
    e.due = cyc + 1 + (mc ? 33 : 0);
    sb.push_back(e);
    start  = 1'b1;
    opcode = op;
    A      = a;
    B      = b;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'(mc));
    opcode = 5'($urandom);
    A      = $urandom;
    B      = $urandom;
    if (poke && mc) begin
      start = 1'b1;
      @(negedge clock);
      start  = 1'b0;
      opcode = 5'($urandom);
      A      = $urandom;
      B      = $urandom;
    end
  endtask

  // Monitor: every done must match the oldest queued expectation at its due cycle
  always @(negedge clock) begin
    exp_t e;
    if (clear && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("Zlowout", 64'(Zlowout), 64'(e.lo));
        chk("Zhighout", 64'(Zhighout), 64'(e.hi));
        chk("dbz", 64'(dbz), 64'(e.dbz));
        chk("err", 64'(err), 64'(e.err));
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    int          g;
    int          k;
    logic [4:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_lo", 64'(Zlowout), 64'd0);
    chk("reset_hi", 64'(Zhighout), 64'd0);
    chk("reset_flags", 64'({dbz, err}), 64'd0);
    clear = 1'b1;
    @(negedge clock);

    do_op(C_ADD, 32'h7, 32'h5, 1'b0);
    do_op(C_MUL, 32'hFFFF_FFFD, 32'h7, 1'b1);
    do_op(C_DIV, 32'hFFFF_FFEF, 32'h5, 1'b1);
    do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(C_DIV, 32'h9, 32'h0, 1'b0);
    do_op(C_ROR, 32'h8000_0001, 32'h4, 1'b0);
    do_op(C_SHRA, 32'h8000_0000, 32'd36, 1'b0);
    do_op(5'b11111, 32'h1234_5678, 32'h9, 1'b0);
    do_op(C_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(C_DIV, 32'h11, 32'hFFFF_FFFB, 1'b0);
    do_op(C_ROL, 32'h8000_0001, 32'h0, 1'b0);
    do_op(C_NEG, 32'h8000_0000, 32'h0, 1'b0);

    for (int i = 0; i < 160; i++) begin
      k  = $urandom_range(0, 14);
      op = (k >= 13) ? 5'($urandom) : ops[k];
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op(op, ra, rb, bit'($urandom_range(0, 1)));
    end

    // Abort a MUL mid-iteration with an asynchronous reset
    do_op(C_DIV, 32'h9, 32'h0, 1'b0);
    do_op(C_MUL, 32'h1234_5678, 32'h0000_0FFF, 1'b0);
    repeat (10) @(posedge clock);
    #2 clear = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_lo", 64'(Zlowout), 64'd0);
    chk("abort_hi", 64'(Zhighout), 64'd0);
    chk("abort_flags", 64'({dbz, err}), 64'd0);
    sb.delete();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    do_op(C_ADD, 32'h1, 32'h1, 1'b0);

    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. It executes the same 5-bit opcode set and adds a start/done handshake, an iterative signed Booth multiplier and an iterative signed divider. Results are held in registered LO/HI output words. It sits between the register-file read ports (A, B) and the Z/HI/LO capture registers, and the control unit sequences it.

## Interface
- `WIDTH`, default 32: operand width. Must be a power of two, ≥ 8.
- `SHAMT_W`, default `$clog2(WIDTH)`: width of the shift/rotate amount. Derived; not overridden.
- `clock`, in, 1: rising-edge clock.
- `clear`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request. Sampled only when `busy`=0.
- `opcode`, in, 5: operation; encoding lives in `alu_pkg`.
- `A`, in, WIDTH: operand A (dividend; shift/rotate source; NEG/NOT source).
- `B`, in, WIDTH: operand B (divisor; shift amount = `B[SHAMT_W-1:0]`).
- `busy`, out, 1: multi-cycle operation in progress.
- `done`, out, 1: one-cycle pulse; results valid.
- `Zlowout`, out, WIDTH: result low word / quotient.
- `Zhighout`, out, WIDTH: result high word / remainder.
- `dbz`, out, 1: last DIV had divisor 0.
- `err`, out, 1: last opcode was unrecognised.

## Operation
- Reset: `busy`, `done`, `dbz`, `err` = 0. `Zlowout`, `Zhighout` = 0. FSM goes to IDLE. A reset mid-operation aborts and discards partial state.
- FSM states: IDLE, MUL, DIV, FIN.
- Single-cycle ops (AND, OR, ADD, SUB, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, and unknown opcodes):
  - Result is written to `Zlowout`. `Zhighout` is written to 0.
  - FSM stays in IDLE.
- Arithmetic is modulo 2^WIDTH; no carry/overflow flags.
- Shift and rotate amounts are taken mod WIDTH. SHRA replicates `A[WIDTH-1]`.
- NEG = two's complement of A. NOT = ~A.
- Unknown opcode: outputs are written to 0 and `err`=1.
- MUL: radix-2 Booth, signed×signed, one iteration per cycle.
  - IDLE→MUL (WIDTH cycles)→FIN→IDLE.
  - The 2·WIDTH-bit product is split: `Zhighout`:`Zlowout`.
- DIV: non-restoring on magnitudes, one bit per cycle, IDLE→DIV (WIDTH cycles)→FIN→IDLE.
  - FIN applies the signs: quotient truncates toward zero, remainder takes the dividend's sign.
  - Quotient goes to `Zlowout`, remainder to `Zhighout`.
  - Most-negative / −1 gives quotient = most-negative, remainder 0.
- Divide by zero is detected in IDLE and completes as a single-cycle op:
  - `Zlowout` = all-ones, `Zhighout` = A, `dbz`=1.
  - MUL/DIV hardware is not entered.
- `dbz` and `err` update on every completion and hold until the next one.
- Operands and opcode are captured at acceptance. Changes on `A`, `B` or `opcode` while `busy` have no effect.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- Accept edge N: `start`=1, `busy`=0.
- Single-cycle ops: results, flags and `done`=1 are registered at edge N and valid in the cycle after it. Latency 1. `busy` stays 0.
- MUL/DIV:
  - `busy`=1 from edge N.
  - Iterations occur at edges N+1 … N+WIDTH.
  - FIN registers results and `done`=1 at edge N+WIDTH+1, and `busy` drops at the same edge. Latency WIDTH+1 (33 at WIDTH=32).
- `done` is high for exactly one cycle. Outputs hold until the next completion.
- Back-to-back: a new `start` is accepted in the cycle `done` is high, so there are no idle cycles between operations.

## Structure
- `alu_pkg`:
  - opcode localparams: AND=00101, OR=00110, ADD=00011, SUB=00100, MUL=10000, DIV=01111, SHR=01001, SHRA=01010, SHL=01011, ROR=00111, ROL=01000, NEG=10001, NOT=10010;
  - FSM state enum.
- Sub-module `seq_muldiv` (WIDTH):
  - holds the iterative Booth/divider datapath, iteration counter and FIN sign fix-up;
  - handshake is `go`/`is_div`/`fin`.
- `seq_alu` holds the single-cycle combinational ops, the FSM, the output registers and the flags.

## Test plan
All scenarios at WIDTH=32; values are hex unless noted.
- ADD: A=7, B=5, pulse `start` → one edge later `done`=1, `Zlowout`=0000000C, `Zhighout`=0, `busy` never set.
- MUL: A=FFFFFFFD (−3), B=7 → `busy` for 33 edges, then `done`; `Zhighout`=FFFFFFFF, `Zlowout`=FFFFFFEB. A second `start` during `busy` is ignored.
- DIV: A=FFFFFFEF (−17), B=5 → after 33 edges `Zlowout`=FFFFFFFD (−3), `Zhighout`=FFFFFFFE (−2), `dbz`=0. Also A=80000000, B=FFFFFFFF → `Zlowout`=80000000, `Zhighout`=0.
- Divide by zero: A=9, B=0, DIV → after 1 edge `done`, `dbz`=1, `Zlowout`=FFFFFFFF, `Zhighout`=00000009.
- Shift/rotate: ROR A=80000001, B=4 → `Zlowout`=18000000. SHRA A=80000000, B=36 (dec) → F8000000. Unknown opcode 11111 → `err`=1, `Zlowout`=0.
- Reset: deassert `clear` at iteration 10 of a MUL → all outputs 0 asynchronously. After release, ADD A=1, B=1 completes with 2 and clean flags.
